// File: rtl/hint_pkg.sv
// Shared constants and helpers for the hint queue.
// Default geometry and the hint bit carrying the arithmetic flag.
package hint_pkg;

    localparam int HINT_ARITH_BIT = 0;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_HINT_W     = 4;
    localparam int DEF_WIN        = 4;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/hint_popcount.sv
// Combinational population count of an N-bit vector.
// Used for the arithmetic-hint tally over the lookahead window.
module hint_popcount #(
    parameter int N = 4
) (
    input  logic [N-1:0]             in_i,
    output logic [$clog2(N+1)-1:0]   cnt_o
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum = sum + CW'(in_i[i]);
        end
    end

    assign cnt_o = sum;

endmodule

// File: rtl/hint_queue.sv
// Circular hint queue with a masked lookahead window.
// Define HINT_QUEUE_ARITH_CNT_EN to enable the arith_cnt popcount.
module hint_queue
    import hint_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int HINT_W = DEF_HINT_W,
    parameter int WIN    = DEF_WIN
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      push_valid,
    output logic                      push_ready,
    input  logic [HINT_W-1:0]         push_hint,
    output logic                      pop_valid,
    input  logic                      pop_ready,
    output logic [HINT_W-1:0]         pop_hint,
    output logic [WIN*HINT_W-1:0]     win_hints,
    output logic [WIN-1:0]            win_valid,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      full,
    output logic                      empty,
    output logic                      overflow,
    output logic [cnt_w(WIN)-1:0]     arith_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [HINT_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              push_fire;
    logic              pop_fire;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign push_ready = !full;
    assign pop_valid  = !empty;
    assign count      = count_q;
    assign overflow   = ovf_q;

    // flush wins over both handshakes
    assign push_fire = push_valid && push_ready && !flush;
    assign pop_fire  = pop_valid && pop_ready && !flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push_fire) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_fire)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({push_fire, pop_fire})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (push_valid && full) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // storage is never cleared; occupancy masks stale entries
    always_ff @(posedge clk) begin
        if (push_fire) mem_q[wr_ptr_q] <= push_hint;
    end

    assign pop_hint = empty ? '0 : mem_q[rd_ptr_q];

    for (genvar i = 0; i < WIN; i++) begin : g_win
        logic [PW-1:0] idx;
        assign idx = rd_ptr_q + PW'(i);
        assign win_valid[i] = (CW'(i) < count_q);
        assign win_hints[i*HINT_W +: HINT_W] =
            win_valid[i] ? mem_q[idx] : '0;
    end

`ifdef HINT_QUEUE_ARITH_CNT_EN
    logic [WIN-1:0] arith_v;

    for (genvar i = 0; i < WIN; i++) begin : g_arith
        assign arith_v[i] = win_valid[i]
            & win_hints[i*HINT_W + HINT_ARITH_BIT];
    end

    hint_popcount #(
        .N(WIN)
    ) u_popcount (
        .in_i (arith_v),
        .cnt_o(arith_cnt)
    );
`else
    assign arith_cnt = '0;
`endif

endmodule

// File: tb/tb_hint_queue.sv
// Scoreboard bench for hint_queue: directed scenarios then random traffic.
// Reference model is a plain SV queue updated from the handshake rules.
module tb_hint_queue;

    localparam int DEPTH  = 8;
    localparam int HINT_W = 4;
    localparam int WIN    = 4;
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int AW     = $clog2(WIN + 1);

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  flush = 1'b0;
    logic                  push_valid = 1'b0;
    logic                  push_ready;
    logic [HINT_W-1:0]     push_hint = '0;
    logic                  pop_valid;
    logic                  pop_ready = 1'b0;
    logic [HINT_W-1:0]     pop_hint;
    logic [WIN*HINT_W-1:0] win_hints;
    logic [WIN-1:0]        win_valid;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic                  overflow;
    logic [AW-1:0]         arith_cnt;

    int checks = 0;
    int failures = 0;

    logic [HINT_W-1:0] ref_q[$];
    bit                ref_ovf = 1'b0;

    hint_queue #(
        .DEPTH (DEPTH),
        .HINT_W(HINT_W),
        .WIN   (WIN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push_valid(push_valid),
        .push_ready(push_ready),
        .push_hint (push_hint),
        .pop_valid (pop_valid),
        .pop_ready (pop_ready),
        .pop_hint  (pop_hint),
        .win_hints (win_hints),
        .win_valid (win_valid),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .arith_cnt (arith_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h",
                     nm, act, exp);
        end
    endtask

    task automatic check_state();
        int n;
        logic [WIN-1:0]        ewv;
        logic [WIN*HINT_W-1:0] ewh;
        int                    ear;
        n   = ref_q.size();
        ewv = '0;
        ewh = '0;
        ear = 0;
        for (int i = 0; i < WIN; i++) begin
            if (i < n) begin
                ewv[i] = 1'b1;
                ewh[i*HINT_W +: HINT_W] = ref_q[i];
                if (ref_q[i][0]) ear++;
            end
        end
`ifndef HINT_QUEUE_ARITH_CNT_EN
        ear = 0;
`endif
        chk("count", 64'(count), 64'(n));
        chk("full", 64'(full), 64'(n == DEPTH));
        chk("empty", 64'(empty), 64'(n == 0));
        chk("push_ready", 64'(push_ready), 64'(n != DEPTH));
        chk("pop_valid", 64'(pop_valid), 64'(n != 0));
        chk("overflow", 64'(overflow), 64'(ref_ovf));
        chk("pop_hint", 64'(pop_hint),
            (n > 0) ? 64'(ref_q[0]) : 64'd0);
        chk("win_valid", 64'(win_valid), 64'(ewv));
        chk("win_hints", 64'(win_hints), 64'(ewh));
        chk("arith_cnt", 64'(arith_cnt), 64'(ear));
    endtask

    // monitor: compare mid-cycle, then advance the model with the
    // inputs the DUT will see at the coming rising edge
    always @(negedge clk) begin
        if (rst) begin
            ref_q.delete();
            ref_ovf = 1'b0;
        end
        check_state();
        if (!rst) begin
            if (flush) begin
                ref_q.delete();
                ref_ovf = 1'b0;
            end else begin
                automatic int  n  = ref_q.size();
                automatic bit  pf = push_valid && (n < DEPTH);
                automatic bit  of = pop_ready && (n > 0);
                if (push_valid && n == DEPTH) ref_ovf = 1'b1;
                if (of) begin
                    chk("pop_data", 64'(pop_hint), 64'(ref_q[0]));
                    void'(ref_q.pop_front());
                end
                if (pf) ref_q.push_back(push_hint);
            end
        end
    end

    task automatic cyc(input bit pv, input logic [HINT_W-1:0] ph,
                       input bit pr, input bit fl);
        push_valid = pv;
        push_hint  = ph;
        pop_ready  = pr;
        flush      = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_ar;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // three pushes, window and arith tally
        cyc(1, 4'h1, 0, 0);
        cyc(1, 4'h2, 0, 0);
        cyc(1, 4'h3, 0, 0);
`ifdef HINT_QUEUE_ARITH_CNT_EN
        exp_ar = 2;
`else
        exp_ar = 0;
`endif
        chk("d3_count", 64'(count), 64'd3);
        chk("d3_win_valid", 64'(win_valid), 64'b0111);
        chk("d3_pop_hint", 64'(pop_hint), 64'h1);
        chk("d3_arith", 64'(arith_cnt), 64'(exp_ar));

        // fill to full, then overflow push
        for (int i = 0; i < 5; i++) cyc(1, HINT_W'(4 + i), 0, 0);
        chk("full_flag", 64'(full), 64'd1);
        chk("full_ready", 64'(push_ready), 64'd0);
        cyc(1, 4'hF, 0, 0);
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_count", 64'(count), 64'd8);
        for (int i = 0; i < 8; i++) cyc(0, 4'h0, 1, 0);
        chk("drained", 64'(empty), 64'd1);

        // pop_ready while empty, then one push
        cyc(0, 4'h0, 1, 0);
        cyc(0, 4'h0, 1, 0);
        cyc(1, 4'h7, 1, 0);
        chk("lat_valid", 64'(pop_valid), 64'd1);
        chk("lat_hint", 64'(pop_hint), 64'h7);
        cyc(0, 4'h0, 1, 0);
        chk("lat_empty", 64'(empty), 64'd1);

        // steady push+pop with wrapping pointers
        for (int i = 0; i < 3; i++) cyc(1, HINT_W'($urandom), 0, 0);
        for (int i = 0; i < 20; i++) cyc(1, HINT_W'($urandom), 1, 0);
        chk("wrap_count", 64'(count), 64'd3);
        cyc(0, 4'h0, 0, 1);

        // count=5 with overflow, then flush with a push
        for (int i = 0; i < 8; i++) cyc(1, HINT_W'($urandom), 0, 0);
        cyc(1, 4'hA, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 4'h0, 1, 0);
        chk("pre_flush_cnt", 64'(count), 64'd5);
        chk("pre_flush_ovf", 64'(overflow), 64'd1);
        cyc(1, 4'hE, 0, 1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_ovf", 64'(overflow), 64'd0);
        chk("flush_empty", 64'(empty), 64'd1);
        cyc(0, 4'h0, 0, 0);
        chk("flush_lost", 64'(pop_valid), 64'd0);

        // asynchronous reset mid-burst
        for (int i = 0; i < 6; i++) cyc(1, HINT_W'(i + 1), 0, 0);
        chk("burst_count", 64'(count), 64'd6);
        push_valid = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_ready", 64'(push_ready), 64'd1);
        chk("rst_pvalid", 64'(pop_valid), 64'd0);
        chk("rst_wvalid", 64'(win_valid), 64'd0);
        chk("rst_whints", 64'(win_hints), 64'd0);
        chk("rst_phint", 64'(pop_hint), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_arith", 64'(arith_cnt), 64'd0);
        push_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1, 4'h9, 0, 0);
        chk("post_rst_cnt", 64'(count), 64'd1);
        chk("post_rst_hint", 64'(pop_hint), 64'h9);

        // random traffic with shifting push/pop bias
        for (int i = 0; i < 600; i++) begin
            automatic int ph = (i / 100) % 3;
            automatic bit pv = ($urandom_range(0, 9) < 3 + 2 * ph);
            automatic bit pr = ($urandom_range(0, 9) < 7 - 2 * ph);
            automatic bit fl = ($urandom_range(0, 49) == 0);
            cyc(pv, HINT_W'($urandom), pr, fl);
        end
        cyc(0, 4'h0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hint_queue.md
HINT_QUEUE -- requirements
Module: hint_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8: queue entries; power of two, >=2.
REQ-002 SHALL have parameter HINT_W, default 4: bits per hint; bit 0 = is_arith.
REQ-003 SHALL have parameter WIN, default 4: lookahead window entries; 1..DEPTH.
REQ-004 SHALL have port clk  in  1  clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port flush  in  1  synchronous queue clear.
REQ-007 SHALL have port push_valid  in  1  producer offers hint.
REQ-008 SHALL have port push_ready  out  1  queue accepts; equals !full.
REQ-009 SHALL have port push_hint  in  HINT_W  offered hint.
REQ-010 SHALL have port pop_valid  out  1  head entry valid; equals !empty.
REQ-011 SHALL have port pop_ready  in  1  consumer takes head.
REQ-012 SHALL have port pop_hint  out  HINT_W  head entry.
REQ-013 SHALL have port win_hints  out  WIN*HINT_W  entries head+0..head+WIN-1; slot i at bits [i*HINT_W +: HINT_W].
REQ-014 SHALL have port win_valid  out  WIN  bit i set iff i < count.
REQ-015 SHALL have port count  out  $clog2(DEPTH+1)  occupancy.
REQ-016 SHALL have port full  out  1  count == DEPTH.
REQ-017 SHALL have port empty  out  1  count == 0.
REQ-018 SHALL have port overflow  out  1  sticky: push attempted while full.
REQ-019 SHALL have port arith_cnt  out  $clog2(WIN+1)  valid window entries with bit 0 set.

Function
REQ-020 SHALL implement circular buffer with rd_ptr, wr_ptr ($clog2(DEPTH) bits, natural wrap) and explicit count register.
REQ-021 Push fire = push_valid && push_ready: write push_hint at wr_ptr, wr_ptr+1.
REQ-022 Pop fire = pop_valid && pop_ready: rd_ptr+1.
REQ-023 count SHALL be +1 on push-only fire, -1 on pop-only fire, unchanged on both or neither.
REQ-024 Simultaneous push and pop fire SHALL be legal whenever 0 < count < DEPTH.
REQ-025 When full, push_ready SHALL be 0, even if pop fires the same cycle (no full bypass).
REQ-026 When empty, pop_ready SHALL be ignored; no pointer or count change.
REQ-027 Push-to-pop latency SHALL be 1 cycle; no combinational push_hint-to-pop_hint path.
REQ-028 pop_hint, win_hints and win_valid SHALL be combinational reads of storage/pointers.
REQ-029 Window slots with win_valid=0 SHALL drive all-zero hint bits.
REQ-030 push_valid && full SHALL set overflow; the hint is dropped and state is unchanged.
REQ-031 flush SHALL have priority over push and pop: pointers and count cleared next cycle, overflow cleared, same-cycle push discarded.
REQ-032 Storage contents SHALL NOT need clearing on flush; masking via win_valid suffices.

Reset
REQ-033 rst SHALL asynchronously clear rd_ptr, wr_ptr, count and overflow.
REQ-034 Outputs in reset SHALL be: empty=1, full=0, push_ready=1, pop_valid=0, count=0, win_valid=0, win_hints=0, pop_hint=0, overflow=0, arith_cnt=0.
REQ-035 Reset asserted mid-traffic SHALL discard all entries; the first push after release behaves as into an empty queue.

Configuration
REQ-036 Macro HINT_QUEUE_ARITH_CNT_EN defined: arith_cnt = popcount over i<WIN of (win_valid[i] & slot_i bit 0), combinational.
REQ-037 Macro absent: arith_cnt SHALL be tied to 0 and no popcount logic SHALL be instantiated; the port list is unchanged.

Structure
REQ-038 Package hint_pkg SHALL hold HINT_ARITH_BIT=0, default DEPTH/HINT_W/WIN constants, and a function computing count width.
REQ-039 Popcount SHALL be sub-module hint_popcount (parameter N, input N bits, output $clog2(N+1) bits), instantiated only under the macro.

Verification
REQ-040 Reset, then push 4'h1, 4'h2, 4'h3 on consecutive cycles -> count=3; win_valid=4'b0111; pop_hint=4'h1; arith_cnt=2 (macro on).
REQ-041 Push 8 entries with no pop -> full=1, push_ready=0; a 9th push -> overflow=1, count stays 8, contents intact.
REQ-042 count=3, push and pop same cycle for 20 cycles (pointers wrap) -> count stays 3; pop order equals push order.
REQ-043 Empty queue with pop_ready=1, then a single push -> pop_valid rises 1 cycle later; pop fires; empty=1 the next cycle.
REQ-044 count=5, overflow=1, assert flush with push_valid=1 -> count=0, overflow=0, empty=1, pushed hint lost.
REQ-045 Assert rst asynchronously mid-burst (count=6) -> outputs match REQ-034 before the next clock edge.
